// File: rtl/mux_scan.sv
// Registered channel multiplexer with manual select and timed auto-scan.
// Optional build macro MUX_SCAN_MASK_EN adds a per-channel enable mask for scanning/selection.
module mux_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    localparam int SW      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SW-1:0]             sel,
    input  logic [CHANNELS*WIDTH-1:0] din,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]          y,
    output logic [SW-1:0]             ch,
    output logic                      valid,
    output logic                      wrap
);

    // state  | meaning
    // IDLE   | disabled, outputs held, valid low
    // MANUAL | y follows din[sel]
    // SCAN   | y walks enabled channels, DWELL cycles each
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MANUAL = 2'd1;
    localparam logic [1:0] S_SCAN   = 2'd2;

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [CHANNELS-1:0] ch_en;

`ifdef MUX_SCAN_MASK_EN
    assign ch_en = ch_mask;
`else
    assign ch_en = '1;
`endif

    logic             sel_in_range;
    logic             sel_en;
    logic [WIDTH-1:0] sel_data;
    logic             cur_en;
    logic [WIDTH-1:0] cur_data;
    logic             any_en;
    logic [SW-1:0]    first_idx;
    logic [WIDTH-1:0] first_data;
    logic [SW-1:0]    next_idx;
    logic [WIDTH-1:0] next_data;
    logic             found;
    logic             wrap_step;

    always_comb begin
        sel_in_range = 1'b0;
        sel_en       = 1'b0;
        sel_data     = '0;
        cur_en       = 1'b0;
        cur_data     = '0;
        any_en       = |ch_en;
        first_idx    = '0;
        first_data   = '0;
        next_idx     = '0;
        next_data    = '0;
        found        = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SW'(k)) begin
                sel_in_range = 1'b1;
                sel_en       = ch_en[k];
                sel_data     = din[k*WIDTH +: WIDTH];
            end
            if (ch == SW'(k)) begin
                cur_en   = ch_en[k];
                cur_data = din[k*WIDTH +: WIDTH];
            end
        end
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (ch_en[k]) first_idx = SW'(k);
        end
        // Next enabled channel above the current one; none means the scan wraps.
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && ch_en[k] && (SW'(k) > ch)) begin
                next_idx = SW'(k);
                found    = 1'b1;
            end
        end
        wrap_step = !found;
        if (!found) next_idx = first_idx;
        for (int k = 0; k < CHANNELS; k++) begin
            if (first_idx == SW'(k)) first_data = din[k*WIDTH +: WIDTH];
            if (next_idx == SW'(k))  next_data  = din[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            y     <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!en) begin
                state <= S_IDLE;
                valid <= 1'b0;
            end else if (!mode) begin
                state <= S_MANUAL;
                if (sel_en) begin
                    ch    <= sel;
                    y     <= sel_data;
                    valid <= 1'b1;
                end else begin
                    valid <= 1'b0;
                    if (!sel_in_range) y <= '0;
                end
            end else begin
                state <= S_SCAN;
                if (!any_en) begin
                    valid <= 1'b0;
                end else if (state != S_SCAN) begin
                    ch    <= first_idx;
                    y     <= first_data;
                    valid <= 1'b1;
                    cnt   <= CNT_LOAD;
                end else if ((cnt == '0) || !cur_en) begin
                    ch    <= next_idx;
                    y     <= next_data;
                    valid <= 1'b1;
                    wrap  <= wrap_step;
                    cnt   <= CNT_LOAD;
                end else begin
                    y     <= cur_data;
                    valid <= 1'b1;
                    cnt   <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: tick-count scan model checked every cycle plus directed literal checks.
// Build with MUX_SCAN_MASK_EN defined to also exercise the channel mask.
module tb_mux_scan;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int DWELL    = 2;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel  = 2'd0;
    logic [31:0] din  = 32'h44332211;
    logic [7:0]  y;
    logic [1:0]  ch;
    logic        valid;
    logic        wrap;
`ifdef MUX_SCAN_MASK_EN
    logic [3:0]  ch_mask = 4'hF;
`endif

    logic [1:0]  sel3 = 2'd0;
    logic [23:0] din3 = 24'hCCBBAA;
    logic [7:0]  y3;
    logic [1:0]  ch3;
    logic        valid3;
    logic        wrap3;

    int errors = 0;
    int checks = 0;
    logic cmp_on = 1'b0;

    always #5 clk = ~clk;

    mux_scan #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(ch_mask),
`endif
        .y(y), .ch(ch), .valid(valid), .wrap(wrap)
    );

    mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel3), .din(din3),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(3'b111),
`endif
        .y(y3), .ch(ch3), .valid(valid3), .wrap(wrap3)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic chan_on(input int k);
`ifdef MUX_SCAN_MASK_EN
        return ch_mask[k];
`else
        return (k >= 0) && (k < CHANNELS);
`endif
    endfunction

    function automatic int n_on();
        int n = 0;
        for (int k = 0; k < CHANNELS; k++) if (chan_on(k)) n++;
        return n;
    endfunction

    // Channel presented t cycles after scan entry: the (t/DWELL)-th enabled channel, cyclically.
    function automatic int scan_ch(input int t);
        int idx = (t / DWELL) % n_on();
        for (int k = 0; k < CHANNELS; k++) begin
            if (chan_on(k)) begin
                if (idx == 0) return k;
                idx--;
            end
        end
        return 0;
    endfunction

    logic [7:0] m_y;
    logic [1:0] m_ch;
    logic       m_valid, m_wrap, m_scan;
    int         m_ticks;
    int         nt;
    assign nt = m_scan ? m_ticks + 1 : 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_y <= 8'h00; m_ch <= 2'd0; m_valid <= 1'b0; m_wrap <= 1'b0;
            m_scan <= 1'b0; m_ticks <= 0;
        end else begin
            m_wrap <= 1'b0;
            if (!en) begin
                m_scan  <= 1'b0;
                m_valid <= 1'b0;
            end else if (!mode) begin
                m_scan <= 1'b0;
                if (chan_on(int'(sel))) begin
                    m_ch    <= sel;
                    m_y     <= din[int'(sel)*8 +: 8];
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (n_on() == 0) begin
                m_valid <= 1'b0;
            end else begin
                m_scan  <= 1'b1;
                m_ticks <= nt;
                m_ch    <= 2'(scan_ch(nt));
                m_y     <= din[scan_ch(nt)*8 +: 8];
                m_valid <= 1'b1;
                m_wrap  <= (nt > 0) && (nt % (DWELL * n_on()) == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_y", int'(y), int'(m_y));
            check("model_ch", int'(ch), int'(m_ch));
            check("model_valid", int'(valid), int'(m_valid));
            check("model_wrap", int'(wrap), int'(m_wrap));
        end
    end

    task automatic tick(input logic e, input logic m, input logic [1:0] s);
        @(negedge clk);
        en = e; mode = m; sel = s;
        @(posedge clk);
        #1;
    endtask

    int seq_y [9] = '{'h11, 'h11, 'h22, 'h22, 'h33, 'h33, 'h44, 'h44, 'h11};
    int seq_m [5] = '{1, 1, 3, 3, 1};

    initial begin
        #1;
        check("reset_y", int'(y), 0);
        check("reset_ch_valid_wrap", int'({ch, valid, wrap}), 0);
        @(negedge clk);
        rst = 1'b0;
        cmp_on = 1'b1;

        tick(1, 0, 2);
        check("man_sel2_y", int'(y), 'h33);
        check("man_sel2_ch", int'(ch), 2);
        check("man_sel2_valid", int'(valid), 1);
        tick(1, 0, 0);
        check("man_sel0_y", int'(y), 'h11);
        check("man_sel0_ch", int'(ch), 0);

        tick(0, 0, 0);
        check("idle_valid", int'(valid), 0);
        check("idle_y_hold", int'(y), 'h11);
        for (int i = 0; i < 9; i++) begin
            tick(1, 1, 0);
            check("scan_seq_y", int'(y), seq_y[i]);
            check("scan_seq_wrap", int'(wrap), (i == 8) ? 1 : 0);
        end

        tick(1, 1, 0);
        tick(1, 1, 0);
        check("scan_ch1_first", int'(ch), 1);
        tick(1, 0, 3);
        check("scan_to_man_y", int'(y), 'h44);
        check("scan_to_man_ch", int'(ch), 3);
        tick(1, 1, 0);
        check("rescan_ch", int'(ch), 0);
        check("rescan_y", int'(y), 'h11);
        check("rescan_wrap", int'(wrap), 0);

        repeat (4) tick(1, 1, 0);
        check("scan_at_ch2", int'(ch), 2);
        tick(0, 1, 0);
        check("dis_valid", int'(valid), 0);
        check("dis_y_hold", int'(y), 'h33);
        check("dis_ch_hold", int'(ch), 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_y", int'(y), 0);
        check("async_rst_ch_valid", int'({ch, valid}), 0);
        @(negedge clk);
        rst = 1'b0;

        tick(1, 1, 0);
        check("post_rst_ch", int'(ch), 0);
        @(negedge clk);
        din = 32'h4433225A;
        @(posedge clk);
        #1;
        check("live_track_y", int'(y), 'h5A);
        check("live_track_ch", int'(ch), 0);
        @(negedge clk);
        din = 32'h44332211;

`ifdef MUX_SCAN_MASK_EN
        tick(0, 0, 0);
        ch_mask = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick(1, 1, 0);
            check("mask_seq_ch", int'(ch), seq_m[i]);
            check("mask_seq_wrap", int'(wrap), (i == 4) ? 1 : 0);
        end
        ch_mask = 4'b0000;
        tick(1, 1, 0);
        check("mask_zero_valid", int'(valid), 0);
        tick(0, 0, 0);
        ch_mask = 4'b1010;
        tick(1, 0, 0);
        check("mask_man_dis_valid", int'(valid), 0);
        tick(0, 0, 0);
        ch_mask = 4'hF;
`endif

        tick(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, 0);
            check("d1_ch", int'(ch3), i % 3);
            check("d1_y", int'(y3), (i % 3 == 0) ? 'hAA : ((i % 3 == 1) ? 'hBB : 'hCC));
            check("d1_wrap", int'(wrap3), (i == 3) ? 1 : 0);
        end
        sel3 = 2'd3;
        tick(1, 0, 0);
        check("oob_sel_y", int'(y3), 0);
        check("oob_sel_valid", int'(valid3), 0);
        check("oob_sel_ch_hold", int'(ch3), 0);

        @(negedge clk);
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
